// File: rtl/sync_ram_dp_param.sv
// Simple-dual-port synchronous RAM with a registered read port and a clear sweep.
// The sweep runs after reset or on request; it initialises every word to INIT_VALUE.
module sync_ram_dp_param #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter bit RDW_NEW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DepthW  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LastPtr = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH:0]   clr_ptr_q;
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic                  wr_hit, rd_hit;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd_word, rd_next;

  assign wr_hit = ({1'b0, wr_addr} < DepthW);
  assign rd_hit = ({1'b0, rd_addr} < DepthW);

  // Single write port shared between the sweep and user writes; reset never writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (state_q == StClear) begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr_q[ADDR_WIDTH-1:0];
        mem_wdata = INIT_VALUE;
      end else if (wr_en && wr_hit) begin
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) ram[mem_addr[IdxW-1:0]] <= mem_wdata;
  end

  always_comb begin
    rd_word = ram[rd_addr[IdxW-1:0]];
    rd_next = INIT_VALUE;
    if (rd_hit) begin
      if (RDW_NEW && wr_en && (wr_addr == rd_addr)) rd_next = wr_data;
      else rd_next = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      busy      <= 1'b1;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          rd_valid  <= 1'b0;
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LastPtr) begin
            state_q <= StReady;
            busy    <= 1'b0;
          end
        end
        StReady: begin
          rd_valid <= rd_en;
          if (rd_en) rd_data <= rd_next;
          // Accesses in the request cycle still complete before the sweep starts.
          if (clr) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
            busy      <= 1'b1;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_ram_dp_param.sv
// Scoreboard bench for sync_ram_dp_param: default, partial-depth/old-data and wide builds
// run against a cycle-level reference of the RAM and its clear sweep.
module tb_sync_ram_dp_param;

  logic       clk = 1'b0;
  logic       rst, clr, wr_en, rd_en;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [7:0] a_rd_data, b_rd_data;
  logic       a_rd_valid, b_rd_valid, a_busy, b_busy;

  logic        w_rst, w_clr, w_wr_en, w_rd_en;
  logic [5:0]  w_wr_addr, w_rd_addr;
  logic [31:0] w_wr_data, w_rd_data;
  logic        w_rd_valid, w_busy;

  always #5 clk = ~clk;

  sync_ram_dp_param dut_a (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy)
  );

  sync_ram_dp_param #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(12), .INIT_VALUE(8'h5A), .RDW_NEW(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy)
  );

  sync_ram_dp_param #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(64), .INIT_VALUE(32'hDEADBEEF), .RDW_NEW(1'b1)
  ) dut_w (
    .clk(clk), .rst(w_rst), .clr(w_clr), .wr_en(w_wr_en), .wr_addr(w_wr_addr),
    .wr_data(w_wr_data), .rd_en(w_rd_en), .rd_addr(w_rd_addr), .rd_data(w_rd_data),
    .rd_valid(w_rd_valid), .busy(w_busy)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference state per build: 0 = default, 1 = partial depth, 2 = wide.
  logic [31:0] mem   [3][64];
  int          left  [3];
  bit          vld   [3];
  bit          armed [3];
  logic [31:0] hold  [3];
  logic [31:0] q0[$], q1[$], q2[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [31:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] pop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qclear(input int k);
    case (k)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic model_step(input int k, input bit r, input bit c, input bit we, input int wa,
                            input logic [31:0] wd, input bit re, input int ra, input int depth,
                            input logic [31:0] init, input bit rdw);
    logic [31:0] v;
    if (r) begin
      armed[k] <= 1'b1;
      left[k]  <= depth;
      vld[k]   <= 1'b0;
      hold[k]  <= '0;
      qclear(k);
    end else if (left[k] > 0) begin
      mem[k][depth-left[k]] <= init;
      left[k] <= left[k] - 1;
      vld[k]  <= 1'b0;
    end else begin
      vld[k] <= re;
      if (re) begin
        if (ra >= depth) v = init;
        else if (rdw && we && wa == ra) v = wd;
        else v = mem[k][ra];
        hold[k] <= v;
        push(k, v);
      end
      if (we && wa < depth) mem[k][wa] <= wd;
      if (c) left[k] <= depth;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst, clr, wr_en, int'(wr_addr), 32'(wr_data), rd_en, int'(rd_addr),
               16, 32'h0, 1'b1);
    model_step(1, rst, clr, wr_en, int'(wr_addr), 32'(wr_data), rd_en, int'(rd_addr),
               12, 32'h5A, 1'b0);
    model_step(2, w_rst, w_clr, w_wr_en, int'(w_wr_addr), w_wr_data, w_rd_en, int'(w_rd_addr),
               64, 32'hDEADBEEF, 1'b1);
  end

  task automatic chk_port(input int k, input logic b, input logic v, input logic [31:0] d);
    if (armed[k]) begin
      check($sformatf("busy%0d", k), 32'(b), 32'(left[k] > 0));
      check($sformatf("rd_valid%0d", k), 32'(v), 32'(vld[k]));
      if (v === 1'b1) begin
        if (qsize(k) == 0) check($sformatf("spurious_valid%0d", k), 32'd1, 32'd0);
        else check($sformatf("rd_data%0d", k), d, pop(k));
      end
      check($sformatf("rd_hold%0d", k), d, hold[k]);
    end
  endtask

  always @(negedge clk) begin
    chk_port(0, a_busy, a_rd_valid, 32'(a_rd_data));
    chk_port(1, b_busy, b_rd_valid, 32'(b_rd_data));
    chk_port(2, w_busy, w_rd_valid, w_rd_data);
  end

  task automatic step(input bit r, input bit c, input bit we, input int wa, input int wd,
                      input bit re, input int ra);
    rst = r; clr = c; wr_en = we; wr_addr = wa[3:0]; wr_data = wd[7:0];
    rd_en = re; rd_addr = ra[3:0];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wstep(input bit r, input bit c, input bit we, input int wa, input int wd,
                       input bit re, input int ra);
    w_rst = r; w_clr = c; w_wr_en = we; w_wr_addr = wa[5:0]; w_wr_data = wd;
    w_rd_en = re; w_rd_addr = ra[5:0];
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      left[k] = 0; vld[k] = 1'b0; armed[k] = 1'b0; hold[k] = '0;
    end
    w_rst = 1'b0; w_clr = 1'b0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
    w_rd_en = 1'b0; w_rd_addr = '0;

    // Initial reset and sweep with reads held on.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 0, 1, i);

    // Fill with A5, pulse reset with rd_en held, then read back the cleared array.
    for (int i = 0; i < 16; i++) step(0, 0, 1, i, 'hA5, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 1, i);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 1, i);

    // Write/read back and hold.
    step(0, 0, 1, 3, 'h3C, 0, 0);
    step(0, 0, 1, 15, 'hF0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 1, 15);
    step(0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Read-during-write at address 5.
    step(0, 0, 1, 5, 'h11, 0, 0);
    step(0, 0, 1, 5, 'h22, 1, 5);
    step(0, 0, 0, 0, 0, 1, 5);

    // Clear request, writes while busy, reset mid-sweep.
    for (int i = 0; i < 16; i++) step(0, 0, 1, i, 'h77, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 2, 'h99, 1, 2);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 2, 'h99, 1, 2);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 1, i);

    // Out-of-range write and read.
    step(0, 0, 1, 13, 'hEE, 0, 0);
    step(0, 0, 0, 0, 0, 1, 13);
    step(0, 0, 0, 0, 0, 1, 11);

    // Clear request coinciding with a write and a read.
    step(0, 0, 1, 4, 'h44, 0, 0);
    step(0, 1, 1, 4, 'h55, 1, 4);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 0, 1, 4);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)));
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0);

    // Wide build: sweep with accesses attempted, pattern fill, readback, clear.
    wstep(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65; i++) wstep(0, 0, 1, i % 64, 'h1234, 1, i % 64);
    for (int i = 0; i < 64; i++) wstep(0, 0, 1, i, (i << 16) | (~i & 'h3F), 0, 0);
    for (int i = 0; i < 64; i++) wstep(0, 0, 0, 0, 0, 1, i);
    wstep(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) wstep(0, 0, 0, 0, 0, 1, 63 - i);
    for (int i = 0; i < 8; i++) wstep(0, 0, 0, 0, 0, 1, i * 9);
    wstep(0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 3; k++) check($sformatf("drained%0d", k), 32'(qsize(k)), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_ram_dp_param.md
# sync_ram_dp_param

Parametrised simple-dual-port synchronous RAM: one write port and one registered read port, both on `clk`. It replaces the bidirectional-bus single-port memory. Ports are split, read latency is one cycle with a valid flag, and a multi-cycle clear sequencer initialises the array after reset or on request. It is the standard storage primitive for buffers and lookup tables in the sequential-logic library.

## Interface

- `ADDR_WIDTH`, default 4: address width.
- `DATA_WIDTH`, default 8: word width.
- `DEPTH`, default 16: number of words.
  - Must satisfy 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- `INIT_VALUE`, default 0: DATA_WIDTH-bit value written by the clear sweep.
- `RDW_NEW`, default 1: read-during-write to the same address.
  - 1 = return the new data.
  - 0 = return the old data.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `clr` input 1: request a full clear sweep. Honoured only in READY.
- `wr_en` input 1: write strobe.
- `wr_addr` input ADDR_WIDTH: write address.
- `wr_data` input DATA_WIDTH: write data.
- `rd_en` input 1: read strobe.
- `rd_addr` input ADDR_WIDTH: read address.
- `rd_data` output DATA_WIDTH: registered read data. Holds its value between reads.
- `rd_valid` output 1: one-cycle pulse, high when `rd_data` was updated by a read.
- `busy` output 1: high while the clear sweep runs. Writes and reads are ignored while high.

## Operation

- The FSM has two states: CLEAR and READY.
- Reset values: state=CLEAR, `clr_ptr`=0, `busy`=1, `rd_data`=0, `rd_valid`=0. The array is not touched in the reset cycle itself.
- CLEAR state:
  - Each cycle writes INIT_VALUE to `ram[clr_ptr]` and increments `clr_ptr`.
  - On the cycle that writes `clr_ptr`=DEPTH-1, the next state is READY and `busy` goes low.
  - `clr_ptr` is ADDR_WIDTH+1 bits wide, so DEPTH=2^ADDR_WIDTH does not wrap early.
- CLEAR ignores inputs:
  - `wr_en`, `rd_en` and `clr` are ignored.
  - `rd_valid` stays 0 and `rd_data` holds its value.
- READY, write: when `wr_en`=1 and `wr_addr`<DEPTH, `ram[wr_addr]` takes `wr_data`. If `wr_addr`≥DEPTH, the write is dropped.
- READY, read: when `rd_en`=1, `rd_data` is loaded and `rd_valid` is 1 for the next cycle. The loaded value is:
  - `ram[rd_addr]` if `rd_addr`<DEPTH;
  - INIT_VALUE if `rd_addr`≥DEPTH.
- READY, no read: when `rd_en`=0, `rd_valid` is 0 and `rd_data` holds.
- Read-during-write: when `wr_en` and `rd_en` are both high with equal in-range addresses:
  - RDW_NEW=1: `rd_data` takes `wr_data`.
  - RDW_NEW=0: `rd_data` takes the pre-write content.
  - The write always completes.
- Clear request: `clr`=1 in READY moves to CLEAR with `clr_ptr`=0 and `busy`=1 next cycle.
  - Any `wr_en` or `rd_en` in that same cycle is still performed. The sweep then overwrites the written word.
- Reset has priority over everything. Asserting `rst` mid-sweep restarts the sweep from 0.

## Timing

- Read latency is 1 cycle: `rd_en` sampled at edge N gives `rd_data`/`rd_valid` valid after edge N. Back-to-back reads give one result per cycle.
- Write latency is 1 cycle: data written at edge N is readable by a read issued at edge N+1, or at edge N under RDW_NEW=1.
- Clear duration is exactly DEPTH cycles.
  - After reset: `rst` is high at edge R and low from then on. The sweep writes at edges R+1 … R+DEPTH.
  - `busy` falls after edge R+DEPTH.
  - The first accepted access is at edge R+DEPTH+1.
- `clr` sampled at edge C: `busy` is high from after edge C through after edge C+DEPTH. The sweep writes at edges C+1 … C+DEPTH.
- No combinational path exists from any input to any output.

## Test plan

- Reset sweep with defaults:
  - Stimulus: write 0xA5 to all 16 addresses, pulse `rst` for one cycle, hold `rd_en`=1 throughout.
  - Required: `busy`=1 for exactly 16 cycles and `rd_valid`=0 during it. Then reading addresses 0–15 returns 0x00, each with `rd_valid` one cycle after `rd_en`.
- Write/read back:
  - Stimulus: write addr 3=0x3C and addr 15=0xF0 on consecutive cycles, then read 3, 15, 3 back-to-back.
  - Required: `rd_data` sequence 0x3C, 0xF0, 0x3C with `rd_valid` high for 3 consecutive cycles. `rd_data` holds 0x3C afterwards with `rd_valid`=0.
- Read-during-write:
  - Stimulus: addr 5 holds 0x11; simultaneous write 0x22 and read of addr 5.
  - Required: `rd_data`=0x22 with RDW_NEW=1, or 0x11 with RDW_NEW=0. A following read returns 0x22 in both builds.
- Clear request and mid-sweep reset:
  - Stimulus: fill with 0x77 and assert `clr`. After 5 sweep cycles assert `rst` for one cycle.
  - Required: `busy` stays high for 16 cycles after the `rst` edge, then all words read INIT_VALUE. A `wr_en` issued while `busy` leaves the target word at INIT_VALUE.
- Partial depth:
  - Stimulus: DEPTH=12, ADDR_WIDTH=4, INIT_VALUE=0x5A. After the sweep, write 0xEE to addr 13, then read 13 and 11.
  - Required: sweep is 12 cycles; reads return 0x5A for both addresses; no write occurs at addr 13.
- Wide configuration:
  - Stimulus: ADDR_WIDTH=6, DEPTH=64, DATA_WIDTH=32. Write address pattern {addr, ~addr} to all 64 addresses, then read all 64 back.
  - Required: every word matches. Reset sweep takes 64 cycles and `clr_ptr` does not wrap early.
